tile_scheduler: RTL
===================

// Module: tile_scheduler
// PURPOSE
//  Game engine sequencer for the piano-tiles datapath. On every game tick it fetches note
//  entries from the song ROM, tracks per-lane note tails, and scrolls the ROWS x LANES tile
//  grid down one row. The grid feeds the LED display driver; the bottom row feeds the scorer.
// PARAMETERS
//  ROWS    12  grid height; row 0 = top (spawn row), row ROWS-1 = bottom (scoring row)
//  LANES   16  grid width; one lane per key/note identifier
//  ADDR_W  8   song ROM address width
// PORTS
//  CLOCK_50    in   1            system clock, 50 MHz
//  reset       in   1            asynchronous, active-high
//  start       in   1            1-cycle pulse: (re)start song from ROM address 0, frame 0
//  tick        in   1            1-cycle strobe per game frame (from period generator)
//  rom_addr    out  ADDR_W       song ROM read address (synchronous ROM, 1-cycle read latency)
//  rom_data    in   16           entry: [15:12] lane, [11:8] length (frames), [7:0] start frame
//  grid        out  ROWS*LANES   tile grid, row r at bits [r*LANES +: LANES]
//  bottom_row  out  LANES        copy of grid row ROWS-1
//  row_valid   out  1            1-cycle pulse: grid/bottom_row just updated
//  frame       out  8            next frame number to be processed
//  busy        out  1            high in FETCH/CHECK/COMMIT
//  overrun     out  1            sticky: tick arrived while busy (cleared by start/reset)
//  song_done   out  1            high in DONE
// BEHAVIOUR
//  Reset: all outputs 0, grid empty, ptr=0, frame=0, lane counters 0, state IDLE.
//  FSM: IDLE -start-> WAIT_TICK -tick-> FETCH -> CHECK -> (FETCH | COMMIT) -> WAIT_TICK | DONE.
//  - FETCH: rom_addr = ptr. CHECK: rom_data valid for that address.
//  - CHECK, entry == 16'hFFFF (sentinel): latch eos, go COMMIT; ptr holds.
//  - CHECK, start field == frame: cnt[lane] <= (length==0 ? 1 : length); ptr++ ; go FETCH.
//    Repeat lane in same frame: later entry overwrites counter.
//  - CHECK, start field != frame: go COMMIT (entry left for a later frame).
//  - ptr reaching 2^ADDR_W-1 after increment is treated as sentinel (eos latched, no wrap).
//  - COMMIT (one cycle): row r <= row r-1 for r=1..ROWS-1; row 0 <= {cnt[l]!=0}; each nonzero
//    cnt decrements; frame <= frame+1 (8-bit wrap 255->0). Outputs change at the edge
//    ending COMMIT; row_valid high for the following cycle.
//  - After COMMIT: eos latched AND new grid empty AND all cnt==0 -> DONE, else WAIT_TICK.
//  Latency: tick sampled cycle t; k matching entries -> row_valid in cycle t+4+2k.
//  ROM entries are sorted by start frame; songs span <=256 frames (equality compare only).
//  tick while busy: dropped, overrun<=1. tick in IDLE/DONE: ignored, no overrun.
//  start in any state: next edge clears grid, counters, ptr, frame, eos, overrun; -> WAIT_TICK.
//  start and tick same cycle: start wins, tick dropped (no overrun).
//  reset mid-song: immediate return to reset values, no row_valid.
// TESTING
//  1 reset, start, ROM {0x0200, 0xFFFF}, tick -> row_valid at t+6; row0 bit0 set (lane 0, 2 frames).
//  2 continue ticks -> lane 0 in rows 0..1 after tick 2; reaches bottom_row bit0 on ticks 12,13;
//    song_done after tick 14 commits empty grid.
//  3 ROM {0x3100,0x7400,0x3201,0xFFFF}: tick0 -> row0=0x0088, row_valid at t+8; tick1 -> row0
//    bits 3,7 (lane 3 reloaded len 2).
//  4 second tick 2 cycles after first -> dropped, overrun=1, frame advances by 1 only.
//  5 length 0 entry -> exactly one tile row; frame 255 commit -> frame wraps to 0.
//  6 start asserted during CHECK -> grid 0, frame 0, rom_addr 0, state WAIT_TICK, no row_valid.

Source files
------------

// File: rtl/tile_scheduler.sv
// tile_scheduler: per-tick song ROM fetch, lane tail counters and ROWS x LANES grid scroll.
module tile_scheduler #(
    parameter int ROWS   = 12,
    parameter int LANES  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  tick,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [15:0]           rom_data,
    output logic [ROWS*LANES-1:0] grid,
    output logic [LANES-1:0]      bottom_row,
    output logic                  row_valid,
    output logic [7:0]            frame,
    output logic                  busy,
    output logic                  overrun,
    output logic                  song_done
);
    typedef enum logic [2:0] {IDLE, WAIT_TICK, FETCH, CHECK, COMMIT, DONE} state_t;
    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d, ptr_inc;
    logic [ROWS*LANES-1:0] grid_q, grid_d, grid_shift;
    logic [3:0]            cnt_q [LANES];
    logic [3:0]            cnt_d [LANES];
    logic [LANES-1:0]      spawn, tail;
    logic [7:0]            frame_q, frame_d;
    logic                  eos_q, eos_d, rv_q, rv_d, ovr_q, ovr_d, sentinel, hit;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign spawn[l] = cnt_q[l] != 4'd0;
        assign tail[l]  = cnt_q[l] > 4'd1;
    end

    assign ptr_inc    = ptr_q + 1'b1;
    assign grid_shift = {grid_q[(ROWS-1)*LANES-1:0], spawn};
    // once end-of-song is latched the ROM is no longer trusted, even if ptr stopped short of a sentinel
    assign sentinel   = eos_q || rom_data == 16'hFFFF;
    assign hit        = !sentinel && rom_data[7:0] == frame_q;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grid_q  <= '0;
            frame_q <= '0;
            eos_q   <= 1'b0;
            rv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            for (int i = 0; i < LANES; i++) cnt_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grid_q  <= grid_d;
            frame_q <= frame_d;
            eos_q   <= eos_d;
            rv_q    <= rv_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_TICK: state_d = tick ? FETCH : WAIT_TICK;
            FETCH:     state_d = CHECK;
            CHECK:     state_d = hit && ptr_inc != '1 ? FETCH : COMMIT;
            COMMIT:    state_d = eos_q && grid_shift == '0 && tail == '0 ? DONE : WAIT_TICK;
            default:   state_d = state_q;
        endcase
        if (start) state_d = WAIT_TICK;
    end

    always_comb begin
        ptr_d   = ptr_q;
        grid_d  = grid_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        eos_d   = eos_q;
        ovr_d   = ovr_q || (tick && busy);
        rv_d    = state_q == COMMIT && !start;
        if (start) begin
            ptr_d   = '0;
            grid_d  = '0;
            frame_d = '0;
            eos_d   = 1'b0;
            ovr_d   = 1'b0;
            for (int i = 0; i < LANES; i++) cnt_d[i] = '0;
        end else if (state_q == CHECK) begin
            eos_d = eos_q || sentinel || (hit && ptr_inc == '1);
            if (hit) begin
                cnt_d[rom_data[15:12]] = rom_data[11:8] == 4'd0 ? 4'd1 : rom_data[11:8];
                ptr_d = ptr_inc;
            end
        end else if (state_q == COMMIT) begin
            grid_d  = grid_shift;
            frame_d = frame_q + 8'd1;
            for (int i = 0; i < LANES; i++) cnt_d[i] = cnt_q[i] - {3'b000, spawn[i]};
        end
    end

    always_comb begin
        rom_addr   = ptr_q;
        grid       = grid_q;
        bottom_row = grid_q[(ROWS-1)*LANES +: LANES];
        row_valid  = rv_q;
        frame      = frame_q;
        busy       = state_q inside {FETCH, CHECK, COMMIT};
        overrun    = ovr_q;
        song_done  = state_q == DONE;
    end
endmodule
